seg_capture_decode: RTL and testbench
=====================================

SEG_CAPTURE_DECODE -- requirements
Module: seg_capture_decode

Interface
REQ-001 The block SHALL have the following parameters: none; the frame length SHALL be fixed at 4 digits.
REQ-002 The block SHALL have the following ports:
- clk  input  1  single clock; all state SHALL change on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- seg  input  7  active-low segment pattern; seg[0]=a through seg[6]=g; 0 = segment lit.
- seg_valid  input  1  seg is sampled on this cycle.
- sof  input  1  start of frame; meaningful only when seg_valid=1; marks digit 0.
- value  output  16  decoded frame; digit k occupies value[4k+3:4k].
- err  output  4  err[k]=1 when digit k held an unrecognised pattern.
- out_valid  output  1  value and err hold a complete frame.
- out_ready  input  1  consumer accepts the frame.
- overrun  output  1  one-cycle pulse when a frame is dropped.

Function
REQ-003 Lit-segment patterns (g..a, 1=lit) SHALL decode as follows:
- 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
- 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
- The lit-segment pattern is ~seg.
REQ-004 Any other pattern SHALL decode to nibble 0x0 with err[k]=1 for that digit.
REQ-005 The block SHALL implement the states IDLE, CAPTURE and HOLD.
REQ-006 In IDLE, seg_valid=1 with sof=1 SHALL store digit 0 and enter CAPTURE with digit index=1.
REQ-007 In IDLE, seg_valid=1 with sof=0 SHALL be ignored.
REQ-008 In CAPTURE, seg_valid=1 with sof=0 SHALL store the digit at the current index and increment the index.
REQ-009 In CAPTURE, storing digit 3 SHALL enter HOLD with out_valid=1 on the next cycle, giving 1-cycle latency from the last beat.
REQ-010 In CAPTURE, seg_valid=1 with sof=1 SHALL discard the partial frame, clear the capture registers, store this beat as digit 0 and set index=1; overrun SHALL NOT pulse.
REQ-011 In CAPTURE, cycles with seg_valid=0 SHALL hold all state; there is no timeout.
REQ-012 Captures SHALL be assembled in shadow registers; value and err SHALL change only on the transition into HOLD.
REQ-013 In HOLD, out_valid=1 and out_ready=1 in the same cycle SHALL complete the handshake; out_valid SHALL drop on the next cycle.
REQ-014 On handshake completion the block SHALL enter IDLE; if that same cycle carries seg_valid=1 with sof=1, it SHALL instead enter CAPTURE with digit 0 stored.
REQ-015 In HOLD without handshake, value, err and out_valid SHALL remain stable.
REQ-016 In HOLD without handshake, seg_valid=1 with sof=1 SHALL pulse overrun for exactly one cycle, and that incoming frame SHALL be dropped.
REQ-017 In HOLD without handshake, beats with sof=0 SHALL be ignored silently.
REQ-018 out_ready SHALL be ignored while out_valid=0.
REQ-019 The digit index SHALL be 2 bits wide and SHALL never wrap past 3 inside CAPTURE.

Reset
REQ-020 resetn=0 SHALL immediately force the state to IDLE and the digit index to 0.
REQ-021 resetn=0 SHALL immediately force value=0x0000, err=0x0, out_valid=0, overrun=0 and clear the shadow registers.
REQ-022 Reset asserted mid-CAPTURE or in HOLD SHALL discard the frame; no out_valid SHALL follow reset release.
REQ-023 The first valid sof after reset release SHALL be captured normally.

Verification
REQ-024 Frame test: beats seg = ~0x06, ~0x5B, ~0x4F, ~0x66 (sof on the first), out_ready=1 -> value=0x4321, err=0x0, out_valid high for exactly 1 cycle, 1 cycle after the last beat.
REQ-025 Invalid-digit test: a frame with digit 2 = seg ~0x00 and the other digits = ~0x71 -> value=0xF0FF, err=0x4.
REQ-026 Backpressure test: out_ready=0 for 10 cycles, then a new sof+beat -> value stable, overrun pulses once, the new frame is dropped; out_ready=1 -> handshake, then IDLE.
REQ-027 Restart test: sof, 2 beats, then sof followed by ~0x7F, ~0x77, ~0x39, ~0x5E -> value=0xDCA8, no overrun.
REQ-028 Reset test: resetn=0 asynchronously after 3 beats -> all outputs 0 before the next clk edge; a full frame after release -> correct value.
REQ-029 Simultaneous test: handshake coincident with a sof beat of ~0x3F, then 3 beats of ~0x6F -> next value=0x9990.

Source files
------------

// File: rtl/seg_capture_decode.sv
// Captures four-digit 7-segment frames and decodes them into hex nibbles.
// Completed frames are held for a valid/ready consumer, and flagged errors mark unrecognised digits.
module seg_capture_decode (
    input  logic        clk,
    input  logic        resetn,
    input  logic [6:0]  seg,
    input  logic        seg_valid,
    input  logic        sof,
    output logic [15:0] value,
    output logic [3:0]  err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [15:0] shadowVal_q, shadowVal_d, value_q;
    logic [3:0]  shadowErr_q, shadowErr_d, err_q;
    logic        outValid_q, overrun_q;

    logic [6:0]  lit;
    logic [3:0]  digitNib;
    logic        digitErr;
    logic [1:0]  beatIdx;
    logic        startBeat;

    assign lit       = ~seg;
    assign startBeat = seg_valid && sof;

    always_comb begin
        digitNib = 4'h0;
        digitErr = 1'b0;
        case (lit)
            7'h3F: digitNib = 4'h0;
            7'h06: digitNib = 4'h1;
            7'h5B: digitNib = 4'h2;
            7'h4F: digitNib = 4'h3;
            7'h66: digitNib = 4'h4;
            7'h6D: digitNib = 4'h5;
            7'h7D: digitNib = 4'h6;
            7'h07: digitNib = 4'h7;
            7'h7F: digitNib = 4'h8;
            7'h6F: digitNib = 4'h9;
            7'h77: digitNib = 4'hA;
            7'h7C: digitNib = 4'hB;
            7'h39: digitNib = 4'hC;
            7'h5E: digitNib = 4'hD;
            7'h79: digitNib = 4'hE;
            7'h71: digitNib = 4'hF;
            default: digitErr = 1'b1;
        endcase
    end

    // A start-of-frame beat always lands in digit 0 of a freshly cleared shadow.
    always_comb begin
        beatIdx     = sof ? 2'd0 : idx_q;
        shadowVal_d = sof ? 16'h0000 : shadowVal_q;
        shadowErr_d = sof ? 4'h0 : shadowErr_q;
        shadowVal_d[{beatIdx, 2'b00} +: 4] = digitNib;
        shadowErr_d[beatIdx]               = digitErr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            shadowVal_q <= 16'h0000;
            shadowErr_q <= 4'h0;
            value_q     <= 16'h0000;
            err_q       <= 4'h0;
            outValid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (startBeat) begin
                        shadowVal_q <= shadowVal_d;
                        shadowErr_q <= shadowErr_d;
                        idx_q       <= 2'd1;
                        state_q     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (seg_valid) begin
                        if (!sof && idx_q == 2'd3) begin
                            value_q    <= shadowVal_d;
                            err_q      <= shadowErr_d;
                            outValid_q <= 1'b1;
                            idx_q      <= 2'd0;
                            state_q    <= HOLD;
                        end else begin
                            shadowVal_q <= shadowVal_d;
                            shadowErr_q <= shadowErr_d;
                            idx_q       <= sof ? 2'd1 : idx_q + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        if (startBeat) begin
                            shadowVal_q <= shadowVal_d;
                            shadowErr_q <= shadowErr_d;
                            idx_q       <= 2'd1;
                            state_q     <= CAPTURE;
                        end else begin
                            idx_q   <= 2'd0;
                            state_q <= IDLE;
                        end
                    end else if (startBeat) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign value     = value_q;
    assign err       = err_q;
    assign out_valid = outValid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_capture_decode.sv
// Directed testbench for seg_capture_decode: stimulus pushes expected frames into a queue,
// and a negedge monitor pops and compares them on every accepted output frame.
module tb_seg_capture_decode;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic        seg_valid = 1'b0;
    logic        sof = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] value;
    logic [3:0]  err;
    logic        out_valid;
    logic        overrun;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
    } exp_t;

    exp_t expQ[$];
    exp_t popped;
    int   nChecks = 0;
    int   nFail = 0;
    int   overrunCount = 0;
    int   ovBefore;
    int   waitCycles;

    seg_capture_decode dut (
        .clk       (clk),
        .resetn    (resetn),
        .seg       (seg),
        .seg_valid (seg_valid),
        .sof       (sof),
        .value     (value),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; leaves the bus idle at the following posedge+1.
    task automatic applyStimulus(input logic [6:0] s, input logic isSof);
        seg       = s;
        sof       = isSof;
        seg_valid = 1'b1;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic syncEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input logic [15:0] v, input logic [3:0] e);
        exp_t x;
        x.v = v;
        x.e = e;
        expQ.push_back(x);
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (overrun) overrunCount++;
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'd1, 32'd0);
                end else if (out_ready) begin
                    popped = expQ.pop_front();
                    checkOutput("frameValue", {16'h0, value}, {16'h0, popped.v});
                    checkOutput("frameErr", {28'h0, err}, {28'h0, popped.e});
                end
            end
        end
    end

    initial begin
        #2 resetn = 1'b0;
        #1;
        checkOutput("resetValue", {16'h0, value}, 32'h0);
        checkOutput("resetErr", {28'h0, err}, 32'h0);
        checkOutput("resetValid", {31'h0, out_valid}, 32'h0);
        checkOutput("resetOverrun", {31'h0, overrun}, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        syncEdge();

        // Basic frame with immediate acceptance
        out_ready = 1'b1;
        pushExpected(16'h4321, 4'h0);
        applyStimulus(~7'h06, 1'b1);
        applyStimulus(~7'h5B, 1'b0);
        applyStimulus(~7'h4F, 1'b0);
        applyStimulus(~7'h66, 1'b0);
        @(negedge clk);
        checkOutput("latencyValid", {31'h0, out_valid}, 32'd1);
        @(negedge clk);
        checkOutput("singleCycleValid", {31'h0, out_valid}, 32'd0);
        syncEdge();

        // Unrecognised digit 2
        pushExpected(16'hF0FF, 4'h4);
        applyStimulus(~7'h71, 1'b1);
        applyStimulus(~7'h71, 1'b0);
        applyStimulus(~7'h00, 1'b0);
        applyStimulus(~7'h71, 1'b0);
        repeat (3) syncEdge();

        // Backpressure: held frame stays stable, a new sof is dropped with one overrun pulse
        out_ready = 1'b0;
        pushExpected(16'h8765, 4'h0);
        applyStimulus(~7'h6D, 1'b1);
        applyStimulus(~7'h7D, 1'b0);
        applyStimulus(~7'h07, 1'b0);
        applyStimulus(~7'h7F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("holdValue", {16'h0, value}, 32'h8765);
            checkOutput("holdValid", {31'h0, out_valid}, 32'd1);
        end
        syncEdge();
        ovBefore = overrunCount;
        applyStimulus(~7'h06, 1'b1);
        applyStimulus(~7'h5B, 1'b0);
        @(negedge clk);
        checkOutput("overrunOnce", overrunCount, ovBefore + 1);
        checkOutput("holdAfterDrop", {16'h0, value}, 32'h8765);
        syncEdge();
        out_ready = 1'b1;
        repeat (3) syncEdge();
        checkOutput("idleAfterAccept", {31'h0, out_valid}, 32'd0);
        applyStimulus(~7'h4F, 1'b0);
        applyStimulus(~7'h66, 1'b0);
        repeat (2) syncEdge();

        // Restart mid-frame discards the partial capture silently
        ovBefore = overrunCount;
        pushExpected(16'hDCA8, 4'h0);
        applyStimulus(~7'h06, 1'b1);
        applyStimulus(~7'h5B, 1'b0);
        applyStimulus(~7'h4F, 1'b0);
        applyStimulus(~7'h7F, 1'b1);
        applyStimulus(~7'h77, 1'b0);
        applyStimulus(~7'h39, 1'b0);
        applyStimulus(~7'h5E, 1'b0);
        repeat (3) syncEdge();
        checkOutput("restartNoOverrun", overrunCount, ovBefore);
        checkOutput("restartValueHeld", {16'h0, value}, 32'hDCA8);

        // Asynchronous reset mid-capture
        applyStimulus(~7'h3F, 1'b1);
        applyStimulus(~7'h06, 1'b0);
        applyStimulus(~7'h5B, 1'b0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("asyncRstValue", {16'h0, value}, 32'h0);
        checkOutput("asyncRstErr", {28'h0, err}, 32'h0);
        checkOutput("asyncRstValid", {31'h0, out_valid}, 32'h0);
        checkOutput("asyncRstOverrun", {31'h0, overrun}, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        applyStimulus(~7'h4F, 1'b0);
        repeat (3) syncEdge();
        checkOutput("noValidAfterRst", {31'h0, out_valid}, 32'd0);
        pushExpected(16'h3210, 4'h0);
        applyStimulus(~7'h3F, 1'b1);
        applyStimulus(~7'h06, 1'b0);
        applyStimulus(~7'h5B, 1'b0);
        applyStimulus(~7'h4F, 1'b0);
        repeat (3) syncEdge();

        // Handshake coinciding with a new sof beat
        out_ready = 1'b0;
        ovBefore = overrunCount;
        pushExpected(16'h1111, 4'h0);
        applyStimulus(~7'h06, 1'b1);
        applyStimulus(~7'h06, 1'b0);
        applyStimulus(~7'h06, 1'b0);
        applyStimulus(~7'h06, 1'b0);
        repeat (2) syncEdge();
        pushExpected(16'h9990, 4'h0);
        out_ready = 1'b1;
        applyStimulus(~7'h3F, 1'b1);
        applyStimulus(~7'h6F, 1'b0);
        applyStimulus(~7'h6F, 1'b0);
        applyStimulus(~7'h6F, 1'b0);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 50) begin
            @(posedge clk);
            waitCycles++;
        end
        repeat (2) syncEdge();
        checkOutput("drainQueue", expQ.size(), 32'd0);
        checkOutput("simulNoOverrun", overrunCount, ovBefore);
        checkOutput("finalValue", {16'h0, value}, 32'h9990);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
